ropuf_eval_ctrl: RTL and testbench

Evaluation sequencer for the multi-bit ring-oscillator PUF. On a start request it drives the PUF's challenge, counter reset and oscillator enable through a fixed clear/run/settle/sample schedule. It repeats each evaluation for majority voting, optionally sweeps every challenge, and presents one packed, voted response word with a stability flag. It sits between the host/test logic and the PUF core.

---
 rtl/ropuf_eval_ctrl_if.sv | 32 +++
 rtl/ropuf_eval_ctrl.sv | 151 +++++++++++++++
 tb/tb_ropuf_eval_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ropuf_eval_ctrl_if.sv
// Host/PUF-side signal bundle for the RO-PUF evaluation sequencer.
interface ropuf_eval_ctrl_if #(
    parameter int unsigned CHAL_W = 2,
    parameter int unsigned RESP_W = 2
);
    localparam int unsigned OUT_W = RESP_W * (1 << CHAL_W);

    logic              start;
    logic              sweep;
    logic [CHAL_W-1:0] chal_in;
    logic [RESP_W-1:0] puf_response;
    logic [CHAL_W-1:0] puf_chal;
    logic              puf_enable;
    logic              puf_reset;
    logic              busy;
    logic              done;
    logic              resp_valid;
    logic [OUT_W-1:0]  resp_out;
    logic              unstable;

    // Host and PUF-core side (drives requests and the PUF response).
    modport master (
        output start, sweep, chal_in, puf_response,
        input  puf_chal, puf_enable, puf_reset, busy, done, resp_valid, resp_out, unstable
    );

    // Sequencer side.
    modport slave (
        input  start, sweep, chal_in, puf_response,
        output puf_chal, puf_enable, puf_reset, busy, done, resp_valid, resp_out, unstable
    );
endinterface

// File: rtl/ropuf_eval_ctrl.sv
// RO-PUF evaluation sequencer: clear/run/settle/sample schedule, majority
// voting over VOTES evaluations, optional sweep over all challenges.
module ropuf_eval_ctrl #(
    parameter int unsigned CHAL_W     = 2,
    parameter int unsigned RESP_W     = 2,
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned WIN_CYC    = 1024,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned VOTES      = 3
) (
    input  logic              clk,
    input  logic              reset,
    ropuf_eval_ctrl_if.slave  bus
);
    localparam int unsigned N_CHAL = 1 << CHAL_W;
    localparam int unsigned OUT_W  = RESP_W * N_CHAL;
    localparam int unsigned CNT_W  = $clog2(VOTES + 1);
    localparam int unsigned VIDX_W = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int unsigned CYC_W  = $clog2(RST_CYC + WIN_CYC + SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t            state;
    logic [CYC_W-1:0]  cyc;
    logic [VIDX_W-1:0] vidx;
    logic [CNT_W-1:0]  cnt [RESP_W];
    logic [CHAL_W-1:0] chal;
    logic              sweep_q;
    logic              puf_enable_q;
    logic              puf_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              resp_valid_q;
    logic [OUT_W-1:0]  resp_out_q;
    logic              unstable_q;

    logic [CNT_W-1:0]  cnt_new [RESP_W];
    logic [RESP_W-1:0] vote_bit;
    logic [RESP_W-1:0] split;

    // Vote counts including the response sampled this cycle, and their verdict.
    always_comb begin
        for (int i = 0; i < int'(RESP_W); i++) begin
            cnt_new[i]  = cnt[i] + CNT_W'(bus.puf_response[i]);
            vote_bit[i] = (cnt_new[i] > CNT_W'(VOTES / 2));
            split[i]    = (cnt_new[i] != '0) && (cnt_new[i] != CNT_W'(VOTES));
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cyc          <= '0;
            vidx         <= '0;
            chal         <= '0;
            sweep_q      <= 1'b0;
            puf_enable_q <= 1'b0;
            puf_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_out_q   <= '0;
            unstable_q   <= 1'b0;
            for (int i = 0; i < int'(RESP_W); i++) cnt[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    puf_reset_q  <= 1'b1;
                    puf_enable_q <= 1'b0;
                    if (bus.start) begin
                        sweep_q      <= bus.sweep;
                        chal         <= bus.sweep ? '0 : bus.chal_in;
                        resp_out_q   <= '0;
                        unstable_q   <= 1'b0;
                        resp_valid_q <= 1'b0;
                        vidx         <= '0;
                        for (int i = 0; i < int'(RESP_W); i++) cnt[i] <= '0;
                        cyc          <= CYC_W'(RST_CYC - 1);
                        busy_q       <= 1'b1;
                        state        <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (cyc == '0) begin
                        puf_reset_q  <= 1'b0;
                        puf_enable_q <= 1'b1;
                        cyc          <= CYC_W'(WIN_CYC - 1);
                        state        <= S_RUN;
                    end else begin
                        cyc <= cyc - 1'b1;
                    end
                end
                S_RUN: begin
                    if (cyc == '0) begin
                        puf_enable_q <= 1'b0;
                        cyc          <= CYC_W'(SETTLE_CYC - 1);
                        state        <= S_SETTLE;
                    end else begin
                        cyc <= cyc - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cyc == '0) state <= S_SAMPLE;
                    else           cyc   <= cyc - 1'b1;
                end
                S_SAMPLE: begin
                    cyc <= CYC_W'(RST_CYC - 1);
                    if (vidx < VIDX_W'(VOTES - 1)) begin
                        for (int i = 0; i < int'(RESP_W); i++) cnt[i] <= cnt_new[i];
                        vidx        <= vidx + 1'b1;
                        puf_reset_q <= 1'b1;
                        state       <= S_CLR;
                    end else begin
                        if (sweep_q) resp_out_q[int'(chal) * RESP_W +: RESP_W] <= vote_bit;
                        else         resp_out_q[RESP_W-1:0]                    <= vote_bit;
                        unstable_q  <= unstable_q | (|split);
                        for (int i = 0; i < int'(RESP_W); i++) cnt[i] <= '0;
                        vidx        <= '0;
                        puf_reset_q <= 1'b1;
                        if (sweep_q && (chal != CHAL_W'(N_CHAL - 1))) begin
                            chal  <= chal + 1'b1;
                            state <= S_CLR;
                        end else begin
                            done_q       <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.puf_chal   = chal;
    assign bus.puf_enable = puf_enable_q;
    assign bus.puf_reset  = puf_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.unstable   = unstable_q;
endmodule

// File: tb/tb_ropuf_eval_ctrl.sv
// Directed self-checking bench for ropuf_eval_ctrl (RST=2, WIN=16, SETTLE=2, VOTES=3).
module tb_ropuf_eval_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   mode;        // 0: constant 2'b10, 1: {c[0],c[1]}, 2: vote sequence 01/11/01
    int   win_cnt;
    int   win_base;
    int   en_cycles;
    int   en_rises;
    int   run_len;
    int   last_run;
    logic en_prev;

    ropuf_eval_ctrl_if #(.CHAL_W(2), .RESP_W(2)) bus ();

    ropuf_eval_ctrl #(
        .CHAL_W(2), .RESP_W(2), .RST_CYC(2), .WIN_CYC(16), .SETTLE_CYC(2), .VOTES(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF core model.
    always_comb begin
        case (mode)
            0:       bus.puf_response = 2'b10;
            1:       bus.puf_response = {bus.puf_chal[0], bus.puf_chal[1]};
            default: begin
                case (win_cnt - win_base)
                    1:       bus.puf_response = 2'b01;
                    2:       bus.puf_response = 2'b11;
                    3:       bus.puf_response = 2'b01;
                    default: bus.puf_response = 2'b00;
                endcase
            end
        endcase
    end

    // Oscillator-enable window monitor.
    always @(negedge clk) begin
        if (bus.puf_enable) begin
            en_cycles = en_cycles + 1;
            run_len   = run_len + 1;
            if (!en_prev) en_rises = en_rises + 1;
        end else if (en_prev) begin
            win_cnt  = win_cnt + 1;
            last_run = run_len;
            run_len  = 0;
        end
        en_prev = bus.puf_enable;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic sw, input logic [1:0] ch);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.sweep   = sw;
        bus.chal_in = ch;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Waits for done (lat = cycles after acceptance, 0 on timeout); optionally
    // pokes a start with another challenge at cycle poke_at.
    task automatic wait_done(input logic [1:0] exp_chal, input int poke_at,
                             output int lat, output int chal_bad, output int busy_bad);
        lat = 0; chal_bad = 0; busy_bad = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == poke_at) begin
                bus.start = 1'b1; bus.sweep = 1'b1; bus.chal_in = 2'd2;
            end else if (k == poke_at + 1) begin
                bus.start = 1'b0; bus.sweep = 1'b0;
            end
            if (bus.puf_chal !== exp_chal) chal_bad = chal_bad + 1;
            if (bus.busy !== 1'b1) busy_bad = busy_bad + 1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, cbad, bbad, e0, r0, extra;
        checks = 0; failures = 0; mode = 0;
        win_cnt = 0; win_base = 0; en_cycles = 0; en_rises = 0;
        run_len = 0; last_run = 0; en_prev = 1'b0;
        bus.start = 1'b0; bus.sweep = 1'b0; bus.chal_in = 2'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_puf_reset", 64'(bus.puf_reset), 64'd1);
        check("rst_puf_enable", 64'(bus.puf_enable), 64'd0);
        check("rst_outputs", 64'({bus.busy, bus.done, bus.resp_valid, bus.unstable}), 64'd0);
        check("rst_resp_chal", 64'({bus.resp_out, bus.puf_chal}), 64'd0);
        reset = 1'b0;

        // Single mode, chal 2, response 10.
        mode = 0; e0 = en_cycles; r0 = en_rises;
        start_job(1'b0, 2'd2);
        wait_done(2'd2, -5, lat, cbad, bbad);
        check("single_latency", 64'(lat), 64'd64);
        check("single_chal_held", 64'(cbad), 64'd0);
        check("single_busy", 64'(bbad), 64'd0);
        check("single_resp", 64'(bus.resp_out), 64'h02);
        check("single_valid_unstable", 64'({bus.resp_valid, bus.unstable}), 64'b10);
        check("single_windows", 64'(en_rises - r0), 64'd3);
        check("single_en_cycles", 64'(en_cycles - e0), 64'd48);
        check("single_win_len", 64'(last_run), 64'd16);
        @(negedge clk);
        check("single_post_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check("single_post_valid", 64'(bus.resp_valid), 64'd1);

        // Sweep mode.
        mode = 1;
        start_job(1'b1, 2'd0);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) check("sweep_first_chal", 64'(bus.puf_chal), 64'd0);
            if (bus.done === 1'b1) begin lat = k; break; end
            lat = 0;
        end
        check("sweep_latency", 64'(lat), 64'd253);
        check("sweep_resp", 64'(bus.resp_out), 64'hD8);
        check("sweep_unstable", 64'(bus.unstable), 64'd0);

        // Split vote.
        mode = 2; win_base = win_cnt;
        start_job(1'b0, 2'd0);
        wait_done(2'd0, -5, lat, cbad, bbad);
        check("unstable_latency", 64'(lat), 64'd64);
        check("unstable_resp", 64'(bus.resp_out), 64'h01);
        check("unstable_flag", 64'(bus.unstable), 64'd1);

        // Reset in the RUN phase of the second evaluation.
        mode = 0;
        start_job(1'b0, 2'd1);
        repeat (29) @(negedge clk);
        check("midrst_in_run", 64'({bus.puf_enable, bus.puf_reset}), 64'b10);
        reset = 1'b1;
        #1;
        check("midrst_enable_reset", 64'({bus.puf_enable, bus.puf_reset}), 64'b01);
        check("midrst_busy_valid", 64'({bus.busy, bus.resp_valid, bus.done}), 64'd0);
        check("midrst_resp_chal", 64'({bus.resp_out, bus.puf_chal}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mode = 1;
        start_job(1'b0, 2'd3);
        wait_done(2'd3, -5, lat, cbad, bbad);
        check("after_rst_latency", 64'(lat), 64'd64);
        check("after_rst_resp", 64'({bus.resp_out, bus.unstable}), 64'({8'h03, 1'b0}));

        // Start during SETTLE is ignored.
        mode = 1;
        start_job(1'b0, 2'd1);
        wait_done(2'd1, 19, lat, cbad, bbad);
        check("busy_start_latency", 64'(lat), 64'd64);
        check("busy_start_chal", 64'(cbad), 64'd0);
        check("busy_start_resp", 64'(bus.resp_out), 64'h02);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra = extra + 1;
        end
        check("busy_start_one_done", 64'(extra), 64'd0);
        check("busy_start_idle", 64'(bus.busy), 64'd0);

        // Back-to-back jobs with start held high.
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.sweep = 1'b0; bus.chal_in = 2'd0;
        @(posedge clk);
        wait_done(2'd0, -5, lat, cbad, bbad);
        check("b2b_first_latency", 64'(lat), 64'd64);
        @(negedge clk);
        check("b2b_idle_cycle", 64'({bus.busy, bus.resp_valid, bus.puf_reset}), 64'b011);
        @(negedge clk);
        check("b2b_second_clr", 64'({bus.busy, bus.resp_valid, bus.puf_reset}), 64'b101);
        check("b2b_resp_cleared", 64'(bus.resp_out), 64'd0);
        bus.start = 1'b0;
        lat = 0;
        for (int k = 2; k <= 400; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        check("b2b_second_latency", 64'(lat), 64'd64);
        check("b2b_second_resp", 64'(bus.resp_out), 64'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
